// File: rtl/collector_i2c_seq.sv
// collector_i2c_seq: Wishbone master that sequences the collector I2C core
// to sample a temp/humidity sensor. It programs the prescaler once after reset,
// then runs one measurement per period or per i_trig. A measurement is an
// address write, a command write, a conversion wait and a 4-byte read.
// Optional feature macro: COLLECTOR_I2C_SEQ_TIMEOUT_EN bounds every TIP poll loop.
module collector_i2c_seq #(
  parameter logic [15:0] PRESCALE    = 16'd23,
  parameter logic [6:0]  SENSOR_ADDR = 7'h40,
  parameter logic [7:0]  MEAS_CMD    = 8'hF5,
  parameter logic [23:0] PERIOD_CYC  = 24'd12000000,
  parameter logic [19:0] CONV_CYC    = 20'd600000,
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_trig,
  output logic [4:0]  o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [15:0] o_hum,
  output logic [15:0] o_temp,
  output logic        o_valid,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  localparam logic [3:0] ST_INIT     = 4'd0;
  localparam logic [3:0] ST_IDLE     = 4'd1;
  localparam logic [3:0] ST_TXR      = 4'd2;
  localparam logic [3:0] ST_CR       = 4'd3;
  localparam logic [3:0] ST_POLL     = 4'd4;
  localparam logic [3:0] ST_RXR      = 4'd5;
  localparam logic [3:0] ST_WAIT     = 4'd6;
  localparam logic [3:0] ST_ABT_CR   = 4'd7;
  localparam logic [3:0] ST_ABT_POLL = 4'd8;

  localparam logic [4:0] A_PRERLO = 5'h00;
  localparam logic [4:0] A_PRERHI = 5'h04;
  localparam logic [4:0] A_CTR    = 5'h08;
  localparam logic [4:0] A_TXR    = 5'h0C;
  localparam logic [4:0] A_CR     = 5'h10;

  // ph: INIT register index (0..2), or measurement phase:
  // 0 addr write, 1 command, 2 read addr, 3..6 data bytes 0..3
  logic [3:0]  st_q, st_d;
  logic [2:0]  ph_q, ph_d;
  logic        stb_q, stb_d, we_q, we_d;
  logic [4:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [23:0] per_q, per_d;
  logic [19:0] conv_q, conv_d;
  logic [23:0] rx_q, rx_d;
  logic [15:0] hum_q, hum_d, temp_q, temp_d;
  logic        valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [1:0]  code_q, code_d, abrt_q, abrt_d;
  logic [4:0]  req_adr;
  logic [7:0]  req_dat;
  logic        req_we;
  logic        tick, start, conv_done, tmo_exp;

  assign tick      = i_en && (per_q == PERIOD_CYC - 24'd1);
  assign start     = (st_q == ST_IDLE) && (i_trig || tick);
  assign conv_done = ({1'b0, conv_q} + 21'd1) >= {1'b0, CONV_CYC};

`ifdef COLLECTOR_I2C_SEQ_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        unused_rdt;
  assign unused_rdt = ^i_wb_rdt[31:8];
  assign tmo_exp    = (tmo_q >= TIMEOUT_CYC);

  // Poll-loop timer: restarts whenever a poll state is entered, saturates
  always_comb begin
    tmo_d = '0;
    if ((st_d == ST_POLL || st_d == ST_ABT_POLL) && st_d == st_q)
      tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
  end

  // Poll-loop timer register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{i_wb_rdt[31:8], TIMEOUT_CYC};
  assign tmo_exp    = 1'b0;
`endif

  // Bus request (address/data/direction) for the current state and phase
  always_comb begin
    req_adr = A_CR;
    req_dat = '0;
    req_we  = 1'b0;
    case (st_q)
      ST_INIT: begin
        req_we = 1'b1;
        case (ph_q)
          3'd0:    begin req_adr = A_PRERLO; req_dat = PRESCALE[7:0];  end
          3'd1:    begin req_adr = A_PRERHI; req_dat = PRESCALE[15:8]; end
          default: begin req_adr = A_CTR;    req_dat = 8'h80;          end
        endcase
      end
      ST_TXR: begin
        req_adr = A_TXR;
        req_we  = 1'b1;
        case (ph_q)
          3'd0:    req_dat = {SENSOR_ADDR, 1'b0};
          3'd1:    req_dat = MEAS_CMD;
          default: req_dat = {SENSOR_ADDR, 1'b1};
        endcase
      end
      ST_CR: begin
        req_we = 1'b1;
        case (ph_q)
          3'd0, 3'd2: req_dat = 8'h90;
          3'd1:       req_dat = 8'h50;
          3'd6:       req_dat = 8'h68;
          default:    req_dat = 8'h20;
        endcase
      end
      ST_RXR:    req_adr = A_TXR;
      ST_ABT_CR: begin req_we = 1'b1; req_dat = 8'h40; end
      default:   ;
    endcase
  end

  // Sequencer: bus handshake, measurement phases, abort handling, period timer
  always_comb begin
    st_d    = st_q;    ph_d   = ph_q;   stb_d  = stb_q;  we_d   = we_q;
    adr_d   = adr_q;   dat_d  = dat_q;  conv_d = conv_q; rx_d   = rx_q;
    hum_d   = hum_q;   temp_d = temp_q; busy_d = busy_q; code_d = code_q;
    abrt_d  = abrt_q;  valid_d = 1'b0;  err_d  = 1'b0;
    per_d   = (!i_en || tick || start) ? 24'd0 : per_q + 24'd1;

    case (st_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          ph_d   = 3'd0;
          st_d   = ST_TXR;
        end
      end
      ST_WAIT: begin
        if (conv_done) begin
          conv_d = '0;
          ph_d   = 3'd2;
          st_d   = ST_TXR;
        end else begin
          conv_d = conv_q + 20'd1;
        end
      end
      default: begin
        // stb is raised only from a low cycle, which guarantees the idle gap
        if (!stb_q) begin
          stb_d = 1'b1;
          adr_d = req_adr;
          dat_d = req_dat;
          we_d  = req_we;
        end else if (i_wb_ack) begin
          stb_d = 1'b0;
          adr_d = '0;
          dat_d = '0;
          we_d  = 1'b0;
          case (st_q)
            ST_INIT: begin
              if (ph_q == 3'd2) begin ph_d = 3'd0; st_d = ST_IDLE; end
              else ph_d = ph_q + 3'd1;
            end
            ST_TXR:    st_d = ST_CR;
            ST_CR:     st_d = ST_POLL;
            ST_ABT_CR: st_d = ST_ABT_POLL;
            ST_POLL: begin
              if (i_wb_rdt[5]) begin
                abrt_d = 2'd2;
                st_d   = ST_ABT_CR;
              end else if (i_wb_rdt[1]) begin
                if (tmo_exp) begin abrt_d = 2'd3; st_d = ST_ABT_CR; end
              end else if ((ph_q == 3'd0 || ph_q == 3'd2) && i_wb_rdt[7]) begin
                abrt_d = 2'd1;
                st_d   = ST_ABT_CR;
              end else begin
                case (ph_q)
                  3'd0:    begin ph_d = 3'd1; st_d = ST_TXR; end
                  3'd1:    st_d = ST_WAIT;
                  3'd2:    begin ph_d = 3'd3; st_d = ST_CR; end
                  default: st_d = ST_RXR;
                endcase
              end
            end
            ST_RXR: begin
              if (ph_q == 3'd6) begin
                hum_d   = rx_q[23:8];
                temp_d  = {rx_q[7:0], i_wb_rdt[7:0]};
                valid_d = 1'b1;
                busy_d  = 1'b0;
                ph_d    = 3'd0;
                st_d    = ST_IDLE;
              end else begin
                rx_d = {rx_q[15:0], i_wb_rdt[7:0]};
                ph_d = ph_q + 3'd1;
                st_d = ST_CR;
              end
            end
            ST_ABT_POLL: begin
              if (!i_wb_rdt[1] || tmo_exp) begin
                err_d  = 1'b1;
                code_d = abrt_q;
                busy_d = 1'b0;
                ph_d   = 3'd0;
                st_d   = ST_IDLE;
              end
            end
            default: st_d = ST_INIT;
          endcase
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q <= ST_INIT;  ph_q <= '0;   stb_q <= 1'b0;  we_q <= 1'b0;
      adr_q <= '0;      dat_q <= '0;  per_q <= '0;    conv_q <= '0;
      rx_q <= '0;       hum_q <= '0;  temp_q <= '0;   valid_q <= 1'b0;
      err_q <= 1'b0;    busy_q <= 1'b0; code_q <= '0; abrt_q <= '0;
    end else begin
      st_q <= st_d;     ph_q <= ph_d;   stb_q <= stb_d; we_q <= we_d;
      adr_q <= adr_d;   dat_q <= dat_d; per_q <= per_d; conv_q <= conv_d;
      rx_q <= rx_d;     hum_q <= hum_d; temp_q <= temp_d; valid_q <= valid_d;
      err_q <= err_d;   busy_q <= busy_d; code_q <= code_d; abrt_q <= abrt_d;
    end
  end

  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = {24'h0, dat_q};
  assign o_wb_we    = we_q;
  assign o_wb_stb   = stb_q;
  assign o_hum      = hum_q;
  assign o_temp     = temp_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_collector_i2c_seq.sv
// Directed bench for collector_i2c_seq with a behavioural I2C-core WB model
// whose SR/RXR responses are scripted from the stimulus block.
module tb_collector_i2c_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, trig = 1'b0;
  logic [4:0]  adr;
  logic [31:0] dat, rdt;
  logic        we, stb, ack;
  logic [15:0] hum, temp;
  logic        valid, err, busy;
  logic [1:0]  code;

  int vectors = 0, miscompares = 0;

  collector_i2c_seq #(
    .PERIOD_CYC (24'd100),
    .CONV_CYC   (20'd4),
    .TIMEOUT_CYC(16'd50)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_trig(trig),
    .o_wb_adr(adr), .o_wb_dat(dat), .o_wb_we(we), .o_wb_stb(stb),
    .i_wb_rdt(rdt), .i_wb_ack(ack),
    .o_hum(hum), .o_temp(temp), .o_valid(valid), .o_err(err),
    .o_err_code(code), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- I2C core model ----------------
  logic [4:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] rxb[4];
  logic [7:0] last_cr = 8'h00;
  int cr_total = 0, polls = 0, rd_idx = 0;
  int tip_polls = 1, al_at = -1;
  bit nack = 0, tip_stuck = 0;

  function automatic logic [7:0] sr_val();
    if (tip_stuck)                          return 8'h02;
    if (al_at == cr_total && last_cr != 8'h40) return 8'h22;
    if (polls < tip_polls)                  return 8'h02;
    if (nack && last_cr == 8'h90)           return 8'h80;
    return 8'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0; rdt <= '0; polls <= 0; rd_idx <= 0; last_cr <= 8'h00;
    end else if (stb && !ack) begin
      ack <= 1'b1;
      if (we) begin
        wa.push_back(adr);
        wd.push_back(dat[7:0]);
        if (adr == 5'h10) begin
          last_cr  <= dat[7:0];
          cr_total <= cr_total + 1;
          polls    <= 0;
          if (dat[7:0] == 8'h90) rd_idx <= 0;
        end
      end else if (adr == 5'h10) begin
        rdt   <= {24'hA5A5A5, sr_val()};
        polls <= polls + 1;
      end else begin
        rdt    <= {24'hA5A5A5, rxb[rd_idx & 3]};
        rd_idx <= rd_idx + 1;
      end
    end else begin
      ack <= 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  int cyc = 0, vcyc = 0, ecyc = 0, stbc = 0, both = 0, busyov = 0;
  int starts[$];
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid) vcyc <= vcyc + 1;
    if (err)   ecyc <= ecyc + 1;
    if (stb)   stbc <= stbc + 1;
    if (valid && err) both <= both + 1;
    if ((valid || err) && busy) busyov <= busyov + 1;
    if (busy && !busy_prev) starts.push_back(cyc);
    busy_prev <= busy;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected bytes packed MSB-first in exp, n of them
  task automatic chk_seq(input string tag, input int base, input logic [4:0] a,
                         input logic [63:0] exp, input int n);
    int cnt = 0;
    logic [63:0] sh;
    for (int i = base; i < wa.size(); i++) begin
      if (wa[i] == a) begin
        if (cnt < n) begin
          sh = exp >> (8 * (n - 1 - cnt));
          chk($sformatf("%s[%0d]", tag, cnt), {24'h0, wd[i]}, {24'h0, sh[7:0]});
        end
        cnt++;
      end
    end
    chk({tag, "_count"}, 32'(cnt), 32'(n));
  endtask

  task automatic pulse_trig();
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int v0 = vcyc, e0 = ecyc, n = 0;
    while (vcyc == v0 && ecyc == e0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(vcyc != v0 || ecyc != e0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, v0, e0, s0, n;

    // reset state
    #3;
    chk("rst_stb",  {31'h0, stb}, 32'd0);
    chk("rst_outs", {hum, temp}, 32'd0);
    chk("rst_flags", {27'h0, valid, err, busy, code}, 32'd0);
    chk("rst_bus",  {adr, we, dat[25:0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // INIT register programming, then bus quiet
    base = wa.size();
    repeat (20) @(negedge clk);
    chk("init_n", 32'(wa.size() - base), 32'd3);
    chk("init0", {wa[base],   wd[base]},   {19'h0, 5'h00, 8'h17});
    chk("init1", {wa[base+1], wd[base+1]}, {19'h0, 5'h04, 8'h00});
    chk("init2", {wa[base+2], wd[base+2]}, {19'h0, 5'h08, 8'h80});
    s0 = stbc;
    repeat (20) @(negedge clk);
    chk("idle_no_stb", 32'(stbc - s0), 32'd0);

    // normal measurement via i_trig
    rxb[0] = 8'h12; rxb[1] = 8'h34; rxb[2] = 8'h56; rxb[3] = 8'h78;
    base = wa.size(); v0 = vcyc; e0 = ecyc;
    pulse_trig();
    wait_done("meas1", 400);
    chk_seq("meas1_cr", base, 5'h10, 64'h0090_5090_2020_2068, 7);
    chk_seq("meas1_txr", base, 5'h0C, 64'h80F581, 3);
    chk("meas1_hum",  {16'h0, hum},  32'h1234);
    chk("meas1_temp", {16'h0, temp}, 32'h5678);
    chk("meas1_vcyc", 32'(vcyc - v0), 32'd1);
    chk("meas1_noerr", 32'(ecyc - e0), 32'd0);
    chk("meas1_busy", {31'h0, busy}, 32'd0);

    // address NACK abort
    nack = 1;
    base = wa.size(); v0 = vcyc; e0 = ecyc;
    pulse_trig();
    wait_done("nack", 400);
    chk_seq("nack_cr", base, 5'h10, 64'h9040, 2);
    chk("nack_ecyc", 32'(ecyc - e0), 32'd1);
    chk("nack_code", {30'h0, code}, 32'd1);
    chk("nack_hum",  {16'h0, hum}, 32'h1234);
    chk("nack_novalid", 32'(vcyc - v0), 32'd0);
    nack = 0;

    // arbitration lost while reading byte 2
    al_at = cr_total + 6;
    base = wa.size(); e0 = ecyc;
    pulse_trig();
    wait_done("al", 400);
    chk_seq("al_cr", base, 5'h10, 64'h0090_5090_2020_2040, 7);
    chk("al_code", {30'h0, code}, 32'd2);
    chk("al_ecyc", 32'(ecyc - e0), 32'd1);
    chk("al_temp", {16'h0, temp}, 32'h5678);
    al_at = -1;

    // recovery measurement after the abort
    rxb[0] = 8'h9A; rxb[1] = 8'hBC; rxb[2] = 8'hDE; rxb[3] = 8'hF0;
    pulse_trig();
    wait_done("rec", 400);
    chk("rec_hum",  {16'h0, hum},  32'h9ABC);
    chk("rec_temp", {16'h0, temp}, 32'hDEF0);
    chk("rec_code", {30'h0, code}, 32'd2);

    // periodic starts, with an i_trig while busy
    tip_polls = 0;
    base = starts.size(); v0 = vcyc; e0 = ecyc;
    @(negedge clk) en = 1'b1;
    n = 0;
    while (starts.size() < base + 2 && n < 600) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("per_busy_at_trig", {31'h0, busy}, 32'd1);
    pulse_trig();
    n = 0;
    while (starts.size() < base + 4 && n < 600) begin @(negedge clk); n++; end
    chk("per_starts", 32'(starts.size() >= base + 4), 32'd1);
    if (starts.size() >= base + 4) begin
      chk("per_gap1", 32'(starts[base+1] - starts[base]),   32'd100);
      chk("per_gap2", 32'(starts[base+2] - starts[base+1]), 32'd100);
      chk("per_gap3", 32'(starts[base+3] - starts[base+2]), 32'd100);
    end
    @(negedge clk) en = 1'b0;
    wait_done("per_last", 200);
    chk("per_vcnt", 32'(vcyc - v0), 32'(starts.size() - base));
    chk("per_noerr", 32'(ecyc - e0), 32'd0);
    tip_polls = 1;

    // TIP stuck
    tip_stuck = 1;
    e0 = ecyc;
    pulse_trig();
`ifdef COLLECTOR_I2C_SEQ_TIMEOUT_EN
    wait_done("tmo", 400);
    chk("tmo_code", {30'h0, code}, 32'd3);
    chk("tmo_ecyc", 32'(ecyc - e0), 32'd1);
`else
    repeat (300) @(negedge clk);
    chk("stuck_busy", {31'h0, busy}, 32'd1);
    chk("stuck_noerr", 32'(ecyc - e0), 32'd0);
`endif

    // async reset mid-transaction, INIT reruns
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_stb",  {31'h0, stb}, 32'd0);
    chk("arst_busy", {31'h0, busy}, 32'd0);
    chk("arst_hum",  {16'h0, hum}, 32'd0);
    tip_stuck = 0;
    repeat (2) @(negedge clk);
    base = wa.size();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_seq("reinit_ctr", base, 5'h08, 64'h80, 1);
    chk_seq("reinit_lo",  base, 5'h00, 64'h17, 1);

    chk("valid_err_overlap", 32'(both), 32'd0);
    chk("busy_with_pulse", 32'(busyov), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
